// File: rtl/refclk_div_buf_pkg.sv
// Shared types and encodings for the reference-clock divider buffer.
// Optional feature macro: REFCLK_DIV_BUF_CDC_EN (CEB synchronizer), used in refclk_div_chan.
package refclk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } chan_state_e;

  localparam logic [1:0] MODE_DIV   = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_OFF   = 2'b10;

  localparam int DIV_W_DEF = 4;

endpackage

// File: rtl/refclk_div_buf_if.sv
// Channel bundle of the divider buffer: per-channel enables and ratios in, divided clocks and locks out.
interface refclk_div_buf_if #(
  parameter int N_CH  = 2,
  parameter int DIV_W = 4
);

  logic [N_CH-1:0]       CEB;
  logic [N_CH*DIV_W-1:0] DIV;
  logic [N_CH-1:0]       ODIV;
  logic [N_CH-1:0]       LOCK;

  modport master (output CEB, output DIV, input ODIV, input LOCK);
  modport slave  (input CEB, input DIV, output ODIV, output LOCK);

endinterface

// File: rtl/refclk_div_chan.sv
// One divider channel: optional CEB synchronizer, IDLE/RUN/DRAIN FSM, period counter, registered outputs.
// Defining REFCLK_DIV_BUF_CDC_EN inserts a 2-flop synchronizer on ceb.
module refclk_div_chan
  import refclk_div_pkg::*;
#(
  parameter int         DIV_W = DIV_W_DEF,
  parameter logic [1:0] MODE  = MODE_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ceb,
  input  logic [DIV_W-1:0] div,
  output logic             odiv,
  output logic             lock
);

  logic             ceb_s;
  chan_state_e      state_r, state_nxt_s;
  logic [DIV_W-1:0] cnt_r, cnt_nxt_s;
  logic [DIV_W-1:0] div_q_r, div_q_nxt_s;
  logic [DIV_W-1:0] d_s, d_nxt_s;
  logic             boundary_s;
  logic             odiv_r, odiv_nxt_s;
  logic             lock_r, lock_nxt_s;

  // Ratios 0 and 1 cannot form a period, so the counter never runs below 2.
  function automatic logic [DIV_W-1:0] eff_ratio(input logic [DIV_W-1:0] v);
    return (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

`ifdef REFCLK_DIV_BUF_CDC_EN
  logic [1:0] sync_r;

  // Two-flop synchronizer, resets to the disabled level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], ceb};
    end
  end

  assign ceb_s = sync_r[1];
`else
  assign ceb_s = ceb;
`endif

  assign d_s        = eff_ratio(div_q_r);
  assign boundary_s = (state_r != IDLE) && (cnt_r == d_s - DIV_W'(1));

  // Next-state, counter, ratio latch and lock decisions.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    div_q_nxt_s = div_q_r;
    lock_nxt_s  = lock_r;
    case (state_r)
      IDLE: begin
        if (!ceb_s && (div != '0)) begin
          state_nxt_s = RUN;
          div_q_nxt_s = div;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
          lock_nxt_s  = 1'b0;
        end
      end
      RUN, DRAIN: begin
        if (boundary_s) begin
          cnt_nxt_s   = '0;
          div_q_nxt_s = div;
          if ((div == '0) || ((state_r == DRAIN) && ceb_s)) begin
            state_nxt_s = IDLE;
            lock_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = RUN;
            lock_nxt_s  = (div == div_q_r);
          end
        end else begin
          // Mid-period: only the RUN/DRAIN flavour follows the enable, the count is untouched.
          cnt_nxt_s = cnt_r + DIV_W'(1);
          if (ceb_s) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = RUN;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
        div_q_nxt_s = '0;
        lock_nxt_s  = 1'b0;
      end
    endcase
  end

  // Output level is decoded from the next state so ODIV lines up with the counter it describes.
  always_comb begin
    d_nxt_s    = eff_ratio(div_q_nxt_s);
    odiv_nxt_s = 1'b0;
    if (state_nxt_s == IDLE) begin
      odiv_nxt_s = 1'b0;
    end else begin
      case (MODE)
        MODE_DIV:   odiv_nxt_s = (cnt_nxt_s < {1'b0, d_nxt_s[DIV_W-1:1]});
        MODE_PULSE: odiv_nxt_s = (cnt_nxt_s == d_nxt_s - DIV_W'(1));
        default:    odiv_nxt_s = 1'b0;
      endcase
    end
  end

  // Channel state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      div_q_r <= '0;
      odiv_r  <= 1'b0;
      lock_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      div_q_r <= div_q_nxt_s;
      odiv_r  <= odiv_nxt_s;
      lock_r  <= lock_nxt_s;
    end
  end

  assign odiv = odiv_r;
  assign lock = lock_r;

endmodule

// File: rtl/refclk_div_buf.sv
// Multi-channel reference clock divider/pulse generator; N_CH independent refclk_div_chan instances.
// Optional feature macro: REFCLK_DIV_BUF_CDC_EN (per-channel CEB synchronizer).
module refclk_div_buf
  import refclk_div_pkg::*;
#(
  parameter int         N_CH  = 2,
  parameter int         DIV_W = DIV_W_DEF,
  parameter logic [1:0] MODE  = MODE_DIV
) (
  input  logic             CLK,
  input  logic             RSTB,
  refclk_div_buf_if.slave  bus
);

  logic [1:0]      rst_sync_r;
  logic            rst_n_s;
  logic [N_CH-1:0] odiv_s;
  logic [N_CH-1:0] lock_s;

  // Reset asserts asynchronously and releases on the second CLK edge after RSTB rises.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    refclk_div_chan #(
      .DIV_W (DIV_W),
      .MODE  (MODE)
    ) u_chan (
      .clk   (CLK),
      .rst_n (rst_n_s),
      .ceb   (bus.CEB[c]),
      .div   (bus.DIV[c*DIV_W +: DIV_W]),
      .odiv  (odiv_s[c]),
      .lock  (lock_s[c])
    );
  end

  assign bus.ODIV = odiv_s;
  assign bus.LOCK = lock_s;

endmodule

// File: doc/refclk_div_buf.md
REFCLK_DIV_BUF -- requirements
Module: refclk_div_buf

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of independent divider channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 4, width of each channel's divide-ratio field.
REQ-003 SHALL have parameter MODE, default 2'b00, output mode: 00 = divided clock on ODIV, 01 = one-cycle pulse on ODIV, 10/11 = ODIV held 0.
REQ-004 SHALL have one clock and an asynchronous active-low reset: CLK input 1, reference clock; RSTB input 1, reset, active-low, asynchronous assert.
REQ-005 SHALL have the following channel ports:
- CEB input N_CH, per-channel enable, active-low, asynchronous to CLK.
- DIV input N_CH*DIV_W, per-channel divide ratio; channel c occupies bits [c*DIV_W +: DIV_W].
- ODIV output N_CH, per-channel divided clock or pulse.
- LOCK output N_CH, high when the channel is producing periods at a stable ratio.

Function
REQ-006 Each channel SHALL run a state machine with states IDLE, RUN and DRAIN, a counter cnt of DIV_W bits, and a latched ratio div_q of DIV_W bits.
REQ-007 Effective ratio SHALL be d = max(div_q, 2); a DIV value of 0 SHALL mean "channel off".
REQ-008 IDLE -> RUN SHALL occur when ceb_s = 0 and DIV != 0; on that transition, div_q <= DIV and cnt <= 0.
REQ-009 In RUN and DRAIN, cnt SHALL increment each cycle and wrap to 0 after reaching d-1; the wrap cycle is the period boundary.
REQ-010 At a period boundary:
- div_q SHALL reload from DIV.
- If DIV = 0, or the state is DRAIN with ceb_s = 1, the next state SHALL be IDLE.
- Otherwise the next state SHALL be RUN.
REQ-011 ceb_s = 1 during RUN SHALL move the channel to DRAIN. The current period SHALL complete unchanged; periods are never truncated.
REQ-012 ceb_s = 0 during DRAIN SHALL return the channel to RUN with no change to cnt.
REQ-013 MODE 00: ODIV SHALL be registered high while in RUN/DRAIN and cnt < d/2 (floor), otherwise low. For d = 4 this gives 2 high / 2 low; for d = 3, 1 high / 2 low.
REQ-014 MODE 01: ODIV SHALL be high for exactly the cycle in which cnt = d-1.
REQ-015 ODIV SHALL be 0 in IDLE and SHALL never pulse shorter than one full CLK cycle.
REQ-016 LOCK SHALL rise at the first period boundary after entering RUN. It SHALL fall on the cycle a boundary reloads a div_q different from the previous value, and also on entering IDLE.
REQ-017 A DIV change mid-period SHALL have no effect until the next boundary.
REQ-018 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 While RSTB = 0, every channel SHALL be held as follows:
- state = IDLE
- cnt = 0
- div_q = 0
- ODIV = 0
- LOCK = 0
- synchronizer flops = 1 (disabled)
REQ-021 RSTB assertion mid-period SHALL force ODIV low immediately (asynchronously). Deassertion SHALL be released synchronously on CLK.

Configuration
REQ-022 Macro REFCLK_DIV_BUF_CDC_EN, when defined, SHALL insert a 2-flop synchronizer on each CEB bit to produce ceb_s. With CEB low set up before edge E0, ODIV (MODE 00) first rises after edge E2.
REQ-023 Without REFCLK_DIV_BUF_CDC_EN, ceb_s SHALL equal CEB directly, and ODIV first rises after edge E0. In this configuration CEB SHALL be treated as synchronous to CLK.

Structure
REQ-024 Package refclk_div_pkg SHALL hold the following, and nothing channel-specific:
- the state enum (IDLE, RUN, DRAIN)
- the MODE encodings
- the DIV_W default
REQ-025 Sub-module refclk_div_chan SHALL implement one channel, including its synchronizer, FSM, counter and output register. The top level SHALL instantiate it N_CH times.

Verification
REQ-026 Each bench SHALL cover at least the scenarios below:
- MODE 00, DIV = 4, CEB = 0 held -> ODIV repeats 2 high / 2 low; LOCK rises after the first 4-cycle period.
- DIV changed 4 -> 6 at cnt = 1 -> current period finishes at 4 cycles; next period is 3 high / 3 low; LOCK drops for one boundary, then rises again.
- CEB = 1 at cnt = 1 (DIV = 4) -> 2 more full cycles complete the period, then IDLE with ODIV = 0; CEB re-lowered during DRAIN -> continues in RUN with no gap.
- DIV = 0 and DIV = 1 -> with DIV = 0 the channel stays IDLE; with DIV = 1 the ratio is clamped to 2 (1 high / 1 low).
- RSTB pulsed low mid-high-phase -> ODIV and LOCK go 0 asynchronously; after release and CEB = 0, ODIV restarts at cnt = 0 with the macro latency.
- N_CH = 2, MODE 01, DIV = {3,5} -> independent 1-cycle pulses every 3 and every 5 cycles; measure start latency both with and without REFCLK_DIV_BUF_CDC_EN.
